// File: rtl/dmem_lsu.sv
// dmem_lsu: byte-addressable RV32 data memory with a one-cycle load/store response.
// Revision 1.0 - initial release.
`default_nettype none

module dmem_lsu #(
  parameter int DEPTH          = 1024,
  parameter bit CLEAR_ON_RESET = 1'b1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [2:0]  req_funct3,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  output logic [31:0] resp_rdata,
  output logic        resp_err
);

  localparam int            AW       = $clog2(DEPTH);
  localparam logic [AW-1:0] LAST_IDX = AW'(DEPTH - 1);

  typedef enum logic [0:0] {
    CLEAR = 1'b0,
    IDLE  = 1'b1
  } state_t;

  localparam state_t RESET_STATE = CLEAR_ON_RESET ? CLEAR : IDLE;

  state_t        state, state_next;
  logic [AW-1:0] clr_idx;
  logic [31:0]   mem [DEPTH];

  logic          accept;
  logic [AW-1:0] word_idx;
  logic [1:0]    lane;
  logic          err;
  logic [3:0]    byte_en;
  logic [31:0]   wdata_rep;
  logic [31:0]   rword;
  logic [7:0]    rbyte;
  logic [15:0]   rhalf;
  logic [31:0]   load_data;

  assign req_ready = (state == IDLE);
  assign accept    = req_valid & req_ready;
  assign word_idx  = req_addr[AW+1:2];
  assign lane      = req_addr[1:0];

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= RESET_STATE;
      clr_idx <= '0;
    end else begin
      state <= state_next;
      if (state == CLEAR) clr_idx <= clr_idx + AW'(1);
    end
  end

  always_comb begin
    state_next = state;
    if (state == CLEAR && clr_idx == LAST_IDX) state_next = IDLE;
  end

  // Width/alignment decode; stores reuse the lane enables, loads ignore them.
  always_comb begin
    err     = |req_addr[31:AW+2];
    byte_en = 4'b0000;
    case (req_funct3)
      3'd0: byte_en = 4'b0001 << lane;
      3'd1: begin
        byte_en = req_addr[1] ? 4'b1100 : 4'b0011;
        err     = err | req_addr[0];
      end
      3'd2: begin
        byte_en = 4'b1111;
        err     = err | (|lane);
      end
      3'd4: err = err | req_we;
      3'd5: err = err | req_we | req_addr[0];
      default: err = 1'b1;
    endcase
  end

  always_comb begin
    wdata_rep = req_wdata;
    case (req_funct3[1:0])
      2'd0:    wdata_rep = {4{req_wdata[7:0]}};
      2'd1:    wdata_rep = {2{req_wdata[15:0]}};
      default: wdata_rep = req_wdata;
    endcase
  end

  assign rword = mem[word_idx];
  assign rbyte = rword[{lane, 3'b000} +: 8];
  assign rhalf = req_addr[1] ? rword[31:16] : rword[15:0];

  always_comb begin
    load_data = '0;
    case (req_funct3)
      3'd0:    load_data = {{24{rbyte[7]}}, rbyte};
      3'd1:    load_data = {{16{rhalf[15]}}, rhalf};
      3'd2:    load_data = rword;
      3'd4:    load_data = {24'd0, rbyte};
      3'd5:    load_data = {16'd0, rhalf};
      default: load_data = '0;
    endcase
  end

  // The array has no reset; contents survive rst unless the fill runs.
  always_ff @(posedge clk) begin
    if (!rst) begin
      if (state == CLEAR) begin
        mem[clr_idx] <= '0;
      end else if (accept && req_we && !err) begin
        for (int b = 0; b < 4; b++) begin
          if (byte_en[b]) mem[word_idx][8*b +: 8] <= wdata_rep[8*b +: 8];
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      resp_valid <= 1'b0;
      resp_rdata <= '0;
      resp_err   <= 1'b0;
    end else begin
      resp_valid <= accept;
      if (accept) begin
        resp_err   <= err;
        resp_rdata <= (req_we || err) ? 32'd0 : load_data;
      end
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_dmem_lsu.sv
// tb_dmem_lsu: directed and random checks of dmem_lsu against a byte-array reference.
// Revision 1.0 - initial release.
`default_nettype none

module tb_dmem_lsu;

  localparam int DEPTH = 16;
  localparam int BYTES = 4 * DEPTH;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [2:0]  req_funct3;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        resp_valid;
  logic [31:0] resp_rdata;
  logic        resp_err;

  dmem_lsu #(.DEPTH(DEPTH), .CLEAR_ON_RESET(1'b1)) dut (
    .clk        (clk),
    .rst        (rst),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_we     (req_we),
    .req_funct3 (req_funct3),
    .req_addr   (req_addr),
    .req_wdata  (req_wdata),
    .resp_valid (resp_valid),
    .resp_rdata (resp_rdata),
    .resp_err   (resp_err)
  );

  always #5 clk = ~clk;

  int          total = 0;
  int          bad   = 0;
  logic [7:0]  mb [BYTES];
  logic [31:0] exp_rdata = 0;
  logic        exp_err   = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, got, exp);
    end
  endtask

  function automatic int nbytes(input logic [2:0] f3);
    return (f3[1:0] == 2'd0) ? 1 : (f3[1:0] == 2'd1) ? 2 : 4;
  endfunction

  function automatic logic model_err(input logic we, input logic [2:0] f3, input logic [31:0] a);
    if (a >= BYTES) return 1'b1;
    if (f3 == 3 || f3 == 6 || f3 == 7) return 1'b1;
    if (we && (f3 == 4 || f3 == 5)) return 1'b1;
    if ((f3 == 1 || f3 == 5) && (a % 2 != 0)) return 1'b1;
    if (f3 == 2 && (a % 4 != 0)) return 1'b1;
    return 1'b0;
  endfunction

  function automatic logic [31:0] model_load(input logic [2:0] f3, input logic [31:0] a);
    logic [31:0] v = 0;
    int n = nbytes(f3);
    for (int i = 0; i < n; i++) v = v | (32'(mb[a + i]) << (8 * i));
    if (f3 == 0 && v[7])  v = v | 32'hFFFF_FF00;
    if (f3 == 1 && v[15]) v = v | 32'hFFFF_0000;
    return v;
  endfunction

  // Drives one cycle's request, updates the model, then checks the response.
  task automatic step(input logic v, input logic we, input logic [2:0] f3,
                      input logic [31:0] a, input logic [31:0] wd, input string tag);
    logic e;
    int   n;
    req_valid  = v;
    req_we     = we;
    req_funct3 = f3;
    req_addr   = a;
    req_wdata  = wd;
    if (v) begin
      e         = model_err(we, f3, a);
      exp_err   = e;
      exp_rdata = 0;
      if (!e) begin
        if (we) begin
          n = nbytes(f3);
          for (int i = 0; i < n; i++) mb[a + i] = wd[8*i +: 8];
        end else begin
          exp_rdata = model_load(f3, a);
        end
      end
    end
    @(posedge clk); #1;
    chk({tag, " valid"}, 32'(resp_valid), 32'(v));
    chk({tag, " rdata"}, resp_rdata, exp_rdata);
    chk({tag, " err"},   32'(resp_err), 32'(exp_err));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int          cnt;
    logic [2:0]  f3;
    logic [31:0] a;

    rst = 1'b1; req_valid = 0; req_we = 0; req_funct3 = 0; req_addr = 0; req_wdata = 0;
    for (int i = 0; i < BYTES; i++) mb[i] = 8'h00;

    @(posedge clk); @(posedge clk); #1;
    chk("reset valid", 32'(resp_valid), 0);
    chk("reset rdata", resp_rdata, 0);
    chk("reset err",   32'(resp_err), 0);
    chk("reset ready", 32'(req_ready), 0);
    rst = 1'b0;

    // Requests offered during the fill must be ignored.
    req_valid = 1'b1; req_we = 1'b1; req_funct3 = 3'd2; req_addr = 32'h8; req_wdata = 32'hDEAD_BEEF;
    cnt = 0;
    while (!req_ready && cnt < 40) begin
      chk("clear no resp", 32'(resp_valid), 0);
      cnt++;
      @(posedge clk); #1;
    end
    chk("clear length", cnt, 16);
    req_valid = 1'b0;

    step(1, 0, 3'd2, 32'h3C, 0, "lw 3c");
    step(1, 0, 3'd2, 32'h08, 0, "lw 8 after ignored sw");

    step(1, 1, 3'd2, 32'h4, 32'h9302_9203, "sw 4");
    step(1, 1, 3'd0, 32'h5, 32'h0000_00AA, "sb 5");
    step(1, 1, 3'd1, 32'h6, 32'h0000_8001, "sh 6");
    step(1, 0, 3'd2, 32'h4, 0, "lw 4");
    chk("lw 4 literal", resp_rdata, 32'h8001_AA03);
    step(1, 0, 3'd0, 32'h5, 0, "lb 5");
    chk("lb 5 literal", resp_rdata, 32'hFFFF_FFAA);
    step(1, 0, 3'd5, 32'h6, 0, "lhu 6");
    chk("lhu 6 literal", resp_rdata, 32'h0000_8001);
    step(0, 0, 3'd0, 0, 0, "idle hold");

    step(1, 0, 3'd2, 32'h2, 0, "err lw 2");
    step(1, 1, 3'd1, 32'h1, 32'hFFFF, "err sh 1");
    step(1, 0, 3'd3, 32'h4, 0, "err f3=3");
    step(1, 1, 3'd2, BYTES, 32'hFFFF_FFFF, "err sw oob");
    step(1, 0, 3'd2, 32'h4, 0, "lw 4 after errs");
    chk("lw 4 unchanged", resp_rdata, 32'h8001_AA03);

    step(1, 1, 3'd2, 32'h8, 32'h1234_5678, "b2b sw");
    step(1, 0, 3'd2, 32'h8, 0, "b2b lw");
    chk("b2b literal", resp_rdata, 32'h1234_5678);
    step(0, 0, 3'd0, 0, 0, "b2b idle");

    for (int k = 0; k < 300; k++) begin
      f3 = 3'($urandom_range(0, 7));
      a  = ($urandom_range(0, 9) == 0) ? $urandom : 32'($urandom_range(0, BYTES + 7));
      if ($urandom_range(0, 1) == 1) a[1:0] = 2'b00;
      step(1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 1)), f3, a, $urandom, "rand");
    end
    for (int w = 0; w < DEPTH; w++) step(1, 0, 3'd2, 32'(4 * w), 0, "readback");

    // Reset one cycle after an accepted load: the pending response must vanish.
    req_valid = 1'b1; req_we = 1'b0; req_funct3 = 3'd2; req_addr = 32'h4;
    exp_rdata = model_load(3'd2, 32'h4);
    @(posedge clk); #1;
    chk("pre-rst valid", 32'(resp_valid), 1);
    chk("pre-rst rdata", resp_rdata, exp_rdata);
    rst = 1'b1; req_we = 1'b1; req_addr = 32'h8; req_wdata = 32'hFFFF_FFFF;
    @(posedge clk); #1;
    rst = 1'b0;
    chk("rst valid", 32'(resp_valid), 0);
    chk("rst rdata", resp_rdata, 0);
    chk("rst ready", 32'(req_ready), 0);
    for (int i = 0; i < 15; i++) begin
      @(posedge clk); #1;
      chk("reclear valid", 32'(resp_valid), 0);
      chk("reclear ready", 32'(req_ready), 0);
    end
    @(posedge clk); #1;
    chk("reclear end valid", 32'(resp_valid), 0);
    chk("reclear end ready", 32'(req_ready), 1);
    req_valid = 1'b0;
    for (int i = 0; i < BYTES; i++) mb[i] = 8'h00;
    exp_rdata = 0; exp_err = 0;
    for (int w = 0; w < DEPTH; w++) step(1, 0, 3'd2, 32'(4 * w), 0, "post-clear");
    step(0, 0, 3'd0, 0, 0, "final idle");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/dmem_lsu.md
DMEM_LSU -- requirements
Module: dmem_lsu

Interface
REQ-001 Parameter: DEPTH, default 1024, number of 32-bit words; power of two, 2..65536.
REQ-002 Parameter: CLEAR_ON_RESET, default 1; 1 = zero-fill the array after reset, 0 = skip the fill.
REQ-003 Port: clk  input  1  sole clock; all state updates on the rising edge.
REQ-004 Port: rst  input  1  reset, synchronous, active-high.
REQ-005 Port: req_valid  input  1  request present.
REQ-006 Port: req_ready  output  1  block can accept a request this cycle.
REQ-007 Port: req_we  input  1  1 = store, 0 = load.
REQ-008 Port: req_funct3  input  3  RV32 width code: 0 = B, 1 = H, 2 = W, 4 = BU, 5 = HU.
REQ-009 Port: req_addr  input  32  byte address.
REQ-010 Port: req_wdata  input  32  store data, right-aligned.
REQ-011 Port: resp_valid  output  1  one-cycle response pulse.
REQ-012 Port: resp_rdata  output  32  load result, extended to 32 bits.
REQ-013 Port: resp_err  output  1  request rejected; valid only when resp_valid = 1.

Function
REQ-014 States SHALL be CLEAR, IDLE.
- After reset: CLEAR if CLEAR_ON_RESET = 1, else IDLE.
- CLEAR: writes zero to word clr_idx each cycle, clr_idx 0..DEPTH-1.
- CLEAR to IDLE after the write of word DEPTH-1, so CLEAR lasts exactly DEPTH cycles.
REQ-015 req_ready SHALL be 0 in CLEAR and 1 in IDLE; accept = req_valid & req_ready.
REQ-016 Accepted requests SHALL sustain throughput of one per cycle, with no bubbles between back-to-back requests.
REQ-017 Every accepted request SHALL produce exactly one resp_valid pulse on the following cycle.
- resp_valid = 0 in every other cycle.
REQ-018 Word index SHALL be req_addr[log2(DEPTH)+1:2]; byte lane = req_addr[1:0].
REQ-019 Error SHALL be flagged if any of the following holds:
- req_addr >= 4*DEPTH;
- funct3 is 3, 6 or 7;
- store with funct3 4 or 5;
- H/HU with addr[0] = 1;
- W with addr[1:0] != 0.
REQ-020 Store without error SHALL write on the accept edge, bytes only; other bytes of the word are unchanged.
- SB: wdata[7:0] to byte lane.
- SH: wdata[15:0] to lanes {addr[1],0} and {addr[1],1}.
- SW: whole word.
REQ-021 Store SHALL respond with resp_rdata = 0 and resp_err per REQ-019.
REQ-022 Load SHALL return the addressed bytes in resp_rdata.
- B/H: sign-extended.
- BU/HU: zero-extended.
- W: unchanged.
REQ-023 Erroneous request SHALL NOT modify memory; it responds with resp_err = 1 and resp_rdata = 0.
REQ-024 Load accepted in the cycle after a store to the same word SHALL return the post-store data (write-first ordering across cycles).
REQ-025 resp_rdata and resp_err SHALL hold their last values between pulses.
REQ-026 Request inputs SHALL be ignored while req_ready = 0; no response is generated.

Reset
REQ-027 While rst = 1 at an edge, the following SHALL hold:
- resp_valid = 0, resp_rdata = 0, resp_err = 0;
- clr_idx = 0;
- state per REQ-014;
- req_ready = 0 in the cycle after that edge when CLEAR_ON_RESET = 1.
REQ-028 Reset asserted mid-operation SHALL drop any pending response: no resp_valid appears after the reset edge.
- Reset asserted during CLEAR SHALL restart the fill at word 0.
REQ-029 With CLEAR_ON_RESET = 0, memory contents SHALL be preserved across reset.
- With CLEAR_ON_RESET = 1, every word reads 0 after CLEAR completes.

Verification
REQ-030 Clear sequence: DEPTH = 16, rst pulse 1 cycle -> req_ready low exactly 16 cycles, then high; LW at addr 0x3C -> rdata 0x00000000, err 0.
REQ-031 Byte/half stores then LW:
- SW 0x93029203 @ 0x4, then SB 0xAA @ 0x5, then SH 0x8001 @ 0x6 -> LW @ 0x4 returns 0x8001AA03.
- LB @ 0x5 returns 0xFFFFFFAA.
- LHU @ 0x6 returns 0x00008001.
REQ-032 Errors: each of the following -> err 1, rdata 0, and a following LW @ 0x4 is unchanged:
- LW @ 0x2;
- SH @ 0x1;
- funct3 = 3;
- SW @ 4*DEPTH.
REQ-033 Back-to-back: SW 0x12345678 @ 0x8 in cycle N, LW @ 0x8 in cycle N+1 -> resp_valid in N+1 and N+2, rdata 0x12345678 in N+2.
REQ-034 Reset mid-stream: accept LW in cycle N, rst = 1 at edge N+1 -> resp_valid stays 0 through the end of CLEAR.
